// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle sequencer for the RV32I core. Steps each instruction through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath strobes.
//
//   Optional feature macro: MCU_ILLEGAL_TRAP_EN
//     defined   : an illegal opcode parks the unit in TRAP (trap=1) until reset
//     undefined : an illegal opcode retires as a NOP straight from DECODE
//
//   Ports
//     clk, rst        core clock, asynchronous active-high reset
//     opcode          instr[6:0] from IR (sampled in DECODE)
//     branch_taken    comparator result (used in EXEC of a branch)
//     mem_ready       memory completes the current request this cycle
//     mem_req/mem_we  memory request / write request
//     addr_sel        memory address: 0 = PC, 1 = ALU result
//     ir_load         load IR and old-PC register from fetch data
//     pc_write/pc_src PC update strobe / 0 = PC+4, 1 = ALU target
//     imm_sel         immediate format: 0=I 1=S 2=B 3=U 4=J (registered)
//     alu_src_a/b     operand selects (a: rs1/old PC, b: rs2/immediate)
//     alu_op          0=add 1=funct-decoded 2=compare 3=pass B
//     reg_write       register-file write strobe
//     wb_sel          0 = ALU, 1 = memory data, 2 = PC+4
//     trap            illegal-instruction trap
//     state           current state (debug)
//     instret         retired-instruction counter
//
//   Handshake: mem_req is raised in FETCH and MEM and held, together with
//   mem_we and addr_sel, until a cycle in which mem_ready is high; that cycle
//   completes the transfer. mem_ready is ignored whenever mem_req is low.
module multicycle_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        pc_write,
  output logic        pc_src,
  output logic [2:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef MCU_ILLEGAL_TRAP_EN
    , S_TRAP = 3'd5
`endif
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  state_t     state_q;
  logic [6:0] opcode_q;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JAL: is_legal = 1'b1;
      default:                      is_legal = 1'b0;
    endcase
  endfunction

  // OP and illegal opcodes use no immediate; they select 0.
  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OPC_STORE:  imm_of = 3'd1;
      OPC_BRANCH: imm_of = 3'd2;
      OPC_LUI:    imm_of = 3'd3;
      OPC_JAL:    imm_of = 3'd4;
      default:    imm_of = 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= 7'd0;
      imm_sel  <= 3'd0;
      instret  <= 32'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          opcode_q <= opcode;
          imm_sel  <= imm_of(opcode);
          if (is_legal(opcode)) begin
            state_q <= S_EXEC;
          end else begin
`ifdef MCU_ILLEGAL_TRAP_EN
            state_q <= S_TRAP;
`else
            state_q <= S_FETCH;
            instret <= instret + 32'd1;
`endif
          end
        end
        S_EXEC: begin
          case (opcode_q)
            OPC_LOAD, OPC_STORE: state_q <= S_MEM;
            OPC_BRANCH: begin
              state_q <= S_FETCH;
              instret <= instret + 32'd1;
            end
            default: state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (opcode_q == OPC_LOAD) begin
              state_q <= S_WB;
            end else begin
              state_q <= S_FETCH;
              instret <= instret + 32'd1;
            end
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          instret <= instret + 32'd1;
        end
`ifdef MCU_ILLEGAL_TRAP_EN
        S_TRAP: state_q <= S_TRAP;
`endif
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign state = state_q;

  // Strobes are decoded from the current state and the latched opcode; the
  // whole decode is gated off while rst is high so nothing leaks during reset.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 2'd0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    trap      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          case (opcode_q)
            OPC_LOAD, OPC_STORE: alu_src_b = 1'b1;
            OPC_OP:              alu_op = 2'd1;
            OPC_OPIMM: begin
              alu_op    = 2'd1;
              alu_src_b = 1'b1;
            end
            OPC_LUI: begin
              alu_op    = 2'd3;
              alu_src_b = 1'b1;
            end
            OPC_BRANCH: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
              if (branch_taken) begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
              end
            end
            OPC_JAL: begin
              // Jump target old PC + J-imm comes from the ALU, like a taken branch.
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
              pc_write  = 1'b1;
              pc_src    = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode_q == OPC_STORE);
        end
        S_WB: begin
          reg_write = 1'b1;
          if (opcode_q == OPC_LOAD)     wb_sel = 2'd1;
          else if (opcode_q == OPC_JAL) wb_sel = 2'd2;
        end
`ifdef MCU_ILLEGAL_TRAP_EN
        S_TRAP: trap = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: directed per-cycle vectors. The driver
// pushes the hand-computed expected output word for each cycle into exp_q and
// a monitor on the falling edge pops and compares it against the DUT outputs.
module tb_multicycle_control_unit;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BAD    = 7'b1111111;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_write, pc_src;
  logic [2:0]  imm_sel;
  logic        alu_src_a, alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [2:0]  state;
  logic [31:0] instret;

  logic [51:0] exp_q[$];
  string       tag_q[$];
  int          checks;
  int          errors;
  logic [31:0] g_inst;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_load(ir_load), .pc_write(pc_write),
    .pc_src(pc_src), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .trap(trap), .state(state), .instret(instret)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word layout:
  // {state, req, we, asel, irl, pcw, pcs, imm, sa, sb, aop, rw, wbs, trap, instret}
  function automatic logic [51:0] ev(
    input logic [2:0] st, input logic req, input logic we, input logic asel,
    input logic irl, input logic pcw, input logic pcs, input logic [2:0] imm,
    input logic sa, input logic sb, input logic [1:0] aop, input logic rw,
    input logic [1:0] wbs, input logic trp, input logic [31:0] inst);
    ev = {st, req, we, asel, irl, pcw, pcs, imm, sa, sb, aop, rw, wbs, trp, inst};
  endfunction

  // driver: apply inputs for one cycle and queue the expected outputs
  task automatic step(input string nm, input logic r, input logic [6:0] op,
                      input logic rdy, input logic bt, input logic [51:0] e);
    rst          = r;
    opcode       = op;
    mem_ready    = rdy;
    branch_taken = bt;
    exp_q.push_back(e);
    tag_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    logic [51:0] act, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = tag_q.pop_front();
        act = {state, mem_req, mem_we, addr_sel, ir_load, pc_write, pc_src,
               imm_sel, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               trap, instret};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h want %h", nm, act, e);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; opcode = 7'd0; mem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;

    // reset: every strobe low even with mem_ready high
    step("reset", 1, OPC_OP, 1, 0, ev(0, 0,0,0,0,0,0, 0, 0,0,0, 0,0, 0, 0));

    // OP: 0,1,2,4 then retire
    step("op_fetch",  0, OPC_OP, 1, 0, ev(0, 1,0,0,1,1,0, 0, 0,0,0, 0,0, 0, 0));
    step("op_decode", 0, OPC_OP, 1, 0, ev(1, 0,0,0,0,0,0, 0, 0,0,0, 0,0, 0, 0));
    step("op_exec",   0, OPC_OP, 1, 0, ev(2, 0,0,0,0,0,0, 0, 0,0,1, 0,0, 0, 0));
    step("op_wb",     0, OPC_OP, 1, 0, ev(4, 0,0,0,0,0,0, 0, 0,0,0, 1,0, 0, 0));

    // LOAD with two wait cycles in MEM
    step("ld_fetch",  0, OPC_LOAD, 1, 0, ev(0, 1,0,0,1,1,0, 0, 0,0,0, 0,0, 0, 1));
    step("ld_decode", 0, OPC_LOAD, 1, 0, ev(1, 0,0,0,0,0,0, 0, 0,0,0, 0,0, 0, 1));
    step("ld_exec",   0, OPC_LOAD, 1, 0, ev(2, 0,0,0,0,0,0, 0, 0,1,0, 0,0, 0, 1));
    step("ld_mem_w1", 0, OPC_LOAD, 0, 0, ev(3, 1,0,1,0,0,0, 0, 0,0,0, 0,0, 0, 1));
    step("ld_mem_w2", 0, OPC_LOAD, 0, 0, ev(3, 1,0,1,0,0,0, 0, 0,0,0, 0,0, 0, 1));
    step("ld_mem",    0, OPC_LOAD, 1, 0, ev(3, 1,0,1,0,0,0, 0, 0,0,0, 0,0, 0, 1));
    step("ld_wb",     0, OPC_LOAD, 1, 0, ev(4, 0,0,0,0,0,0, 0, 0,0,0, 1,1, 0, 1));

    // BRANCH taken
    step("bt_fetch",  0, OPC_BRANCH, 1, 1, ev(0, 1,0,0,1,1,0, 0, 0,0,0, 0,0, 0, 2));
    step("bt_decode", 0, OPC_BRANCH, 1, 1, ev(1, 0,0,0,0,0,0, 0, 0,0,0, 0,0, 0, 2));
    step("bt_exec",   0, OPC_BRANCH, 1, 1, ev(2, 0,0,0,0,1,1, 2, 1,1,0, 0,0, 0, 2));
    // BRANCH not taken, with one fetch wait
    step("bn_fwait",  0, OPC_BRANCH, 0, 0, ev(0, 1,0,0,0,0,0, 2, 0,0,0, 0,0, 0, 3));
    step("bn_fetch",  0, OPC_BRANCH, 1, 0, ev(0, 1,0,0,1,1,0, 2, 0,0,0, 0,0, 0, 3));
    step("bn_decode", 0, OPC_BRANCH, 1, 0, ev(1, 0,0,0,0,0,0, 2, 0,0,0, 0,0, 0, 3));
    step("bn_exec",   0, OPC_BRANCH, 1, 0, ev(2, 0,0,0,0,0,0, 2, 1,1,0, 0,0, 0, 3));

    // STORE with one wait in MEM
    step("st_fetch",  0, OPC_STORE, 1, 0, ev(0, 1,0,0,1,1,0, 2, 0,0,0, 0,0, 0, 4));
    step("st_decode", 0, OPC_STORE, 1, 0, ev(1, 0,0,0,0,0,0, 2, 0,0,0, 0,0, 0, 4));
    step("st_exec",   0, OPC_STORE, 1, 0, ev(2, 0,0,0,0,0,0, 1, 0,1,0, 0,0, 0, 4));
    step("st_mem_w",  0, OPC_STORE, 0, 0, ev(3, 1,1,1,0,0,0, 1, 0,0,0, 0,0, 0, 4));
    step("st_mem",    0, OPC_STORE, 1, 0, ev(3, 1,1,1,0,0,0, 1, 0,0,0, 0,0, 0, 4));

    // JAL
    step("jal_fetch",  0, OPC_JAL, 1, 0, ev(0, 1,0,0,1,1,0, 1, 0,0,0, 0,0, 0, 5));
    step("jal_decode", 0, OPC_JAL, 1, 0, ev(1, 0,0,0,0,0,0, 1, 0,0,0, 0,0, 0, 5));
    step("jal_exec",   0, OPC_JAL, 1, 0, ev(2, 0,0,0,0,1,1, 4, 1,1,0, 0,0, 0, 5));
    step("jal_wb",     0, OPC_JAL, 1, 0, ev(4, 0,0,0,0,0,0, 4, 0,0,0, 1,2, 0, 5));

    // illegal opcode
    step("bad_fetch",  0, OPC_BAD, 1, 0, ev(0, 1,0,0,1,1,0, 4, 0,0,0, 0,0, 0, 6));
    step("bad_decode", 0, OPC_BAD, 1, 0, ev(1, 0,0,0,0,0,0, 4, 0,0,0, 0,0, 0, 6));
`ifdef MCU_ILLEGAL_TRAP_EN
    step("trap_1",     0, OPC_BAD, 1, 0, ev(5, 0,0,0,0,0,0, 0, 0,0,0, 0,0, 1, 6));
    step("trap_2",     0, OPC_LOAD, 1, 0, ev(5, 0,0,0,0,0,0, 0, 0,0,0, 0,0, 1, 6));
    step("trap_reset", 1, OPC_LOAD, 1, 0, ev(0, 0,0,0,0,0,0, 0, 0,0,0, 0,0, 0, 0));
    g_inst = 32'd0;
`else
    g_inst = 32'd7;
`endif

    // LOAD aborted by reset in MEM
    step("ab_fetch",  0, OPC_LOAD, 1, 0, ev(0, 1,0,0,1,1,0, 0, 0,0,0, 0,0, 0, g_inst));
    step("ab_decode", 0, OPC_LOAD, 1, 0, ev(1, 0,0,0,0,0,0, 0, 0,0,0, 0,0, 0, g_inst));
    step("ab_exec",   0, OPC_LOAD, 1, 0, ev(2, 0,0,0,0,0,0, 0, 0,1,0, 0,0, 0, g_inst));
    step("ab_mem",    0, OPC_LOAD, 0, 0, ev(3, 1,0,1,0,0,0, 0, 0,0,0, 0,0, 0, g_inst));
    step("ab_rst",    1, OPC_LOAD, 1, 0, ev(0, 0,0,0,0,0,0, 0, 0,0,0, 0,0, 0, 0));
    step("ab_refetch_w", 0, OPC_LOAD, 0, 0, ev(0, 1,0,0,0,0,0, 0, 0,0,0, 0,0, 0, 0));
    step("ab_refetch",   0, OPC_LOAD, 1, 0, ev(0, 1,0,0,1,1,0, 0, 0,0,0, 0,0, 0, 0));
    step("ab_decode2",   0, OPC_LOAD, 1, 0, ev(1, 0,0,0,0,0,0, 0, 0,0,0, 0,0, 0, 0));

    // let the monitor drain, then confirm nothing was left unchecked
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and drives the datapath strobes. Those strobes cover the PC, IR, immediate-generator format select, ALU operand/op select, memory handshake and register-file write. It sits between the instruction register/opcode field and the shared single-port memory, immediate generator, ALU and register file.

## Interface
- No parameters.
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  7  instr[6:0] from IR, valid from DECODE onward
- branch_taken  input  1  comparator result, sampled in EXEC of a branch
- mem_ready  input  1  memory completes current request this cycle
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  write request (store data phase only)
- addr_sel  output  1  0 = PC, 1 = ALU result
- ir_load  output  1  load IR and old-PC register from fetch data
- pc_write  output  1  update PC this cycle
- pc_src  output  1  0 = PC+4, 1 = ALU target
- imm_sel  output  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J; to immediate generator
- alu_src_a  output  1  0 = rs1, 1 = old PC
- alu_src_b  output  1  0 = rs2, 1 = immediate
- alu_op  output  2  0 = add, 1 = funct-decoded, 2 = compare, 3 = pass B
- reg_write  output  1  register-file write strobe
- wb_sel  output  2  0 = ALU, 1 = memory data, 2 = PC+4
- trap  output  1  illegal-instruction trap (see Configuration)
- state  output  3  current state, for debug
- instret  output  32  retired-instruction counter

## Operation
- States are FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5. Outputs are decoded from state and opcode_q.
- FETCH:
  - Drives mem_req=1, addr_sel=0.
  - On mem_ready: ir_load=1, pc_write=1, pc_src=0, then go to DECODE.
  - Without mem_ready, stay in FETCH.
- DECODE:
  - Registers opcode into opcode_q and registers imm_sel.
  - imm_sel mapping: LOAD 0000011 and OP-IMM 0010011 → I; STORE 0100011 → S; BRANCH 1100011 → B; LUI 0110111 → U; JAL 1101111 → J; OP 0110011 → 0.
  - Any other opcode is illegal.
  - Always exactly one cycle, then go to EXEC (or TRAP/FETCH if illegal).
- EXEC, by opcode:
  - LOAD/STORE: alu_src_b=1, alu_op=0, go to MEM.
  - OP: alu_op=1, go to WB.
  - OP-IMM: alu_op=1, alu_src_b=1, go to WB.
  - LUI: alu_op=3, alu_src_b=1, go to WB.
  - BRANCH: alu_src_a=1, alu_src_b=1, alu_op=0. If branch_taken, pc_write=1 and pc_src=1. Retire and go to FETCH.
  - JAL: same operand selects as BRANCH, pc_write=1 unconditionally, go to WB.
- MEM:
  - Drives mem_req=1, addr_sel=1, mem_we=(STORE).
  - On mem_ready: LOAD goes to WB; STORE retires and goes to FETCH.
- WB:
  - reg_write=1 for one cycle.
  - wb_sel: 1 for LOAD, 2 for JAL, else 0.
  - Retire and go to FETCH.
- Retire means instret increments by 1 on the transition into FETCH. It wraps 0xFFFFFFFF→0.
- All unlisted strobes are 0 in every state.

## Timing
- Reset (async):
  - state=FETCH, opcode_q=0, imm_sel=0, instret=0.
  - While rst is high, every strobe output is forced to 0, including mem_req.
  - mem_req=1 in the first cycle after release.
- Latency with zero-wait memory (mem_ready tied high):
  - BRANCH: 3 cycles.
  - STORE and ALU/LUI/JAL: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle on mem_ready adds one cycle.
- mem_req and mem_we stay stable while waiting.
- mem_ready seen while mem_req=0 is ignored.
- imm_sel is stable from the cycle after DECODE until the next DECODE.
- rst asserted mid-instruction aborts it: no retire, no partial reg_write. Fetch restarts from the current PC.

## Configuration
- MCU_ILLEGAL_TRAP_EN defined:
  - An illegal opcode in DECODE goes to TRAP.
  - TRAP holds trap=1 with all other strobes 0 until reset.
  - instret does not increment.
- MCU_ILLEGAL_TRAP_EN undefined:
  - An illegal opcode is a NOP.
  - DECODE goes directly to FETCH, retiring the NOP (instret+1).
  - trap is tied to 0 and the TRAP state is absent.

## Test plan
- Reset then release with mem_ready=1 and opcode 0110011 → states 0,1,2,4,0; reg_write high exactly in cycle 4; instret=1.
- LOAD 0000011, mem_ready low for 2 cycles in MEM → mem_req/addr_sel=1 held for 3 cycles; wb_sel=1 in WB; imm_sel=0; 7-cycle instruction.
- BRANCH 1100011 with branch_taken=1, then =0 → pc_write with pc_src=1 in EXEC only when taken; imm_sel=2; 3 cycles each; instret=2.
- STORE 0100011 → mem_we=1 only in MEM; imm_sel=1; no reg_write; returns to FETCH. JAL 1101111 → imm_sel=4, wb_sel=2.
- Opcode 1111111 → with the macro, trap=1 persists and instret stays unchanged; without it, back to FETCH after DECODE and instret+1.
- rst pulsed during MEM of a LOAD → reg_write never asserts; state=0; instret=0; mem_req=0 while rst is high.
